// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and execute-unit state encoding.
// The decoder and the execute unit both import this package.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: accumulator plus down-counter.
// o_next is the value after the next shift step; o_done flags the final step.
module alu_shift_iter #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_dir,
  input  logic                     i_arith,
  input  logic [WIDTH-1:0]         i_value,
  input  logic [$clog2(WIDTH)-1:0] i_shamt,
  output logic                     o_done,
  output logic [WIDTH-1:0]         o_next
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic             r_dir;
  logic             r_fill;

  // Right shifts fill with r_fill, which is the latched sign bit for SRA and 0 for SRL.
  assign o_next = r_dir ? {r_fill, r_acc[WIDTH-1:1]} : {r_acc[WIDTH-2:0], 1'b0};
  assign o_done = (r_cnt == SHW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_fill <= 1'b0;
    end else if (i_start) begin
      r_acc  <= i_value;
      r_cnt  <= i_shamt;
      r_dir  <= i_dir;
      r_fill <= i_arith & i_value[WIDTH-1];
    end else if (r_cnt != '0) begin
      r_acc <= o_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit with valid/ready handshakes on both sides.
// Single-cycle ops resolve at the accept edge; shifts iterate one bit per cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic                illegal_op
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       r_state;
  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  logic [SHW-1:0]   w_shamt;
  logic             w_isShift;
  logic             w_accept;
  logic             w_shiftStart;
  logic [WIDTH-1:0] w_aluResult;
  logic             w_illegal;
  logic             w_shiftDone;
  logic [WIDTH-1:0] w_shiftNext;

  assign w_shamt      = b[SHW-1:0];
  assign w_isShift    = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
  assign in_ready     = (r_state == ST_IDLE) && !reset;
  assign w_accept     = in_valid && in_ready;
  assign w_shiftStart = w_accept && w_isShift && (w_shamt != '0);

  // Single-cycle result; a shift by zero passes a through unchanged.
  always_comb begin
    w_aluResult = '0;
    w_illegal   = 1'b0;
    case (alu_op)
      ALU_ADD:  w_aluResult = a + b;
      ALU_SUB:  w_aluResult = a - b;
      ALU_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_XOR:  w_aluResult = a ^ b;
      ALU_OR:   w_aluResult = a | b;
      ALU_AND:  w_aluResult = a & b;
      ALU_SLL, ALU_SRL, ALU_SRA: w_aluResult = a;
      default:  w_illegal = 1'b1;
    endcase
  end

  alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_shiftStart),
    .i_dir   (alu_op != ALU_SLL),
    .i_arith (alu_op == ALU_SRA),
    .i_value (a),
    .i_shamt (w_shamt),
    .o_done  (w_shiftDone),
    .o_next  (w_shiftNext)
  );

  // Handshake FSM; result, zero and illegal_op only change on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_shiftStart) begin
            r_state <= ST_SHIFT;
          end else if (w_accept) begin
            r_state    <= ST_DONE;
            r_outValid <= 1'b1;
            r_result   <= w_aluResult;
            r_zero     <= (w_aluResult == '0);
            r_illegal  <= w_illegal;
          end
        end
        ST_SHIFT: begin
          if (w_shiftDone) begin
            r_state    <= ST_DONE;
            r_outValid <= 1'b1;
            r_result   <= w_shiftNext;
            r_zero     <= (w_shiftNext == '0);
            r_illegal  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state    <= ST_IDLE;
            r_outValid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = r_outValid;
  assign result     = r_result;
  assign zero       = r_zero;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int checkCount;
  int errCount;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expectation and tallies the outcome.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one op for a single cycle starting at a falling edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    alu_op   = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Runs one op with out_ready high, measuring latency and checking the outputs.
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] expRes, input logic expZero,
                       input logic expIll, input int expLat);
    int lat;
    lat = 0;
    applyStimulus(op, av, bv);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " zero"}, {31'd0, zero}, {31'd0, expZero});
    checkOutput({tag, " illegal"}, {31'd0, illegal_op}, {31'd0, expIll});
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errCount   = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    alu_op     = 4'd0;
    a          = 32'd0;
    b          = 32'd0;

    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset zero", {31'd0, zero}, 32'd0);
    checkOutput("reset illegal", {31'd0, illegal_op}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle in_ready", {31'd0, in_ready}, 32'd1);

    runOp("ADD 5+7",      4'b0000, 32'd5,        32'd7,        32'd12,         1'b0, 1'b0, 1);
    runOp("SUB 3-3",      4'b0001, 32'd3,        32'd3,        32'd0,          1'b1, 1'b0, 1);
    runOp("SLT -1<1",     4'b0011, 32'hFFFFFFFF, 32'd1,        32'd1,          1'b0, 1'b0, 1);
    runOp("SLTU max<1",   4'b0100, 32'hFFFFFFFF, 32'd1,        32'd0,          1'b1, 1'b0, 1);
    runOp("XOR",          4'b0101, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0,   1'b0, 1'b0, 1);
    runOp("OR",           4'b1000, 32'h00000F00, 32'h000000F0, 32'h00000FF0,   1'b0, 1'b0, 1);
    runOp("SRA min by 4", 4'b0111, 32'h80000000, 32'd4,        32'hF8000000,   1'b0, 1'b0, 5);
    runOp("SLL 1 by 37",  4'b0010, 32'd1,        32'h25,       32'h00000020,   1'b0, 1'b0, 6);
    runOp("SRL F0 by 4",  4'b0110, 32'h800000F0, 32'd4,        32'h0800000F,   1'b0, 1'b0, 5);
    runOp("SRL by 0",     4'b0110, 32'h12345678, 32'h20,       32'h12345678,   1'b0, 1'b0, 1);
    runOp("SLL 1 by 31",  4'b0010, 32'd1,        32'd31,       32'h80000000,   1'b0, 1'b0, 32);

    // Backpressure: result must hold and a new request must be ignored.
    out_ready = 1'b0;
    applyStimulus(4'b0000, 32'd10, 32'd20);
    @(negedge clk);
    checkOutput("bp first valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      alu_op   = 4'b0001;
      a        = 32'd99;
      b        = 32'd1;
      in_valid = (k == 1);
      checkOutput("bp held valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp held result", result, 32'd30);
      checkOutput("bp in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp release valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp release in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp result kept", result, 32'd30);

    // Reset asserted during the tenth SHIFT cycle of a long SRL.
    applyStimulus(4'b0110, 32'hFFFFFFFF, 32'd31);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst result", result, 32'd0);
    checkOutput("midrst in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("after rst in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("after rst out_valid", {31'd0, out_valid}, 32'd0);
    runOp("ADD 1+1",      4'b0000, 32'd1,        32'd1,        32'd2,          1'b0, 1'b0, 1);

    runOp("illegal 1111", 4'b1111, 32'd5,        32'd6,        32'd0,          1'b1, 1'b1, 1);
    runOp("AND F0&3C",    4'b1001, 32'hF0,       32'h3C,       32'h30,         1'b0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  // Watchdog so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Multi-cycle integer execute unit. It consumes the 4-bit alu_op code produced by the instruction decoder, together with two operands, and returns a registered result.
- Shifts run iteratively, one bit per cycle. All other ops complete in one cycle.
- Valid/ready handshakes on both sides let it sit between the decode/operand-fetch stage and writeback.

Parameters:
WIDTH, 32, operand/result width in bits. The shift amount is b[$clog2(WIDTH)-1:0].

Ports:
clk  input  1  clock, rising-edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and alu_op valid
in_ready  output  1  unit can accept; high only in IDLE and never while reset is high
alu_op  input  4  operation code (encoding below)
a  input  WIDTH  operand A (value to shift for shift ops)
b  input  WIDTH  operand B (low bits are shamt for shift ops)
out_valid  output  1  result valid
out_ready  input  1  consumer takes the result
result  output  WIDTH  registered result
zero  output  1  registered, result == 0
illegal_op  output  1  registered, alu_op was not a defined code

Behaviour:
- alu_op encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR
  - 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
  - 1010-1111 are illegal.
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port name reset.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, illegal_op=0, shift counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid && in_ready; operands and op are latched on that edge.
  - Non-shift op: result computed and registered at the accept edge, next state DONE. out_valid rises the cycle after accept (latency 1).
  - Shift op with shamt=0: result=a, next state DONE (latency 1).
  - Shift op with shamt>0: accumulator=a, cnt=shamt, next state SHIFT.
- SHIFT:
  - Each cycle: accumulator shifted one bit (SLL zero fill; SRL zero fill; SRA fill with latched a[WIDTH-1]) and cnt decrements.
  - When cnt==1 at an edge, the final shift completes, result is loaded, and next state is DONE.
  - Total latency from accept to out_valid = 1 + shamt cycles (SRA by 4 gives out_valid 5 cycles after the accept edge).
- DONE:
  - out_valid=1; result, zero and illegal_op are held stable.
  - On out_ready=1: next state IDLE and out_valid drops the next cycle.
  - in_ready=0, so no new accept in the same cycle as the handoff. Max throughput is one op per 2 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare, SLTU unsigned; both produce result = {WIDTH-1 zeros, flag}.
  - XOR/OR/AND are bitwise.
- Illegal op: result=0, illegal_op=1, latency 1. Legal ops clear illegal_op.
- in_valid and operands are ignored outside IDLE. out_ready is ignored outside DONE.
- Reset mid-operation (SHIFT or DONE): aborts the op with no out_valid. Returns to IDLE the cycle after reset deasserts with all outputs at reset values.
- zero is computed from the final result value, not from intermediate shift values.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op localparams ALU_ADD ... ALU_AND and ALU_OP_W=4;
  - FSM state encoding ST_IDLE/ST_SHIFT/ST_DONE.
- The decoder and this unit both import alu_pkg so the encoding has a single source.
- One natural sub-module, alu_shift_iter: accumulator plus counter, with start/dir/arith inputs and a done output. The top level keeps the handshake FSM and the single-cycle ops.

Test Plan:
- ADD a=5,b=7 with out_ready=1 -> out_valid exactly 1 cycle after accept; result=12, zero=0, illegal_op=0.
- SUB 3-3 -> result=0, zero=1. SLT a=0xFFFFFFFF,b=1 -> 1. SLTU same operands -> 0.
- SRA a=0x80000000,b=4 -> result 0xF8000000, out_valid 5 cycles after accept. SLL a=1,b=0x25 -> shamt=5, result 0x20, latency 6.
- Backpressure: ADD result held while out_ready=0 for 3 cycles -> result and out_valid stable, in_ready=0, a new in_valid pulse is not accepted. out_ready=1 -> IDLE next cycle.
- Reset during SRL with shamt=31, asserted at the 10th SHIFT cycle -> out_valid=0, result=0 next cycle; after release in_ready=1, and a following ADD 1+1 returns 2.
- alu_op=4'b1111 -> result=0, illegal_op=1, latency 1. A following AND 0xF0&0x3C -> 0x30 with illegal_op=0.
